mem_responder_8085: RTL and testbench

- Byte-wide memory responder: the memory end of the multi-cycle 8085 processor's read/write interface.
- Accepts read/write requests from the controller/datapath, inserts a programmable number of wait states, then returns a one-cycle ready strobe with registered read data or a committed write.
- Holds an internal RAM and provides a side-band load port for program/data initialisation before the processor is released from reset.

---
 rtl/mem_responder_8085.sv | 144 ++++++++++++++
 tb/tb_mem_responder_8085.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_8085.sv
// Byte-wide wait-stated memory responder for the 8085 read/write bus, with side-band loader.
// Optional MEMRESP_OOR_ERR_EN adds err_o and blocks accesses at or beyond DEPTH.
module mem_responder_8085 #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              read_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [7:0]        wdata_i,
   output logic [7:0]        rdata_o,
   output logic              ready_o,
   output logic              busy_o,
   input  logic              ld_en_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [7:0]        ld_data_i
`ifdef MEMRESP_OOR_ERR_EN
   ,
   output logic              err_o
`endif
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              we_q, we_d;
   logic              commit;
   logic [7:0]        mem_q [DEPTH];

   function automatic logic [IdxW-1:0] wrap_idx(input logic [ADDR_W-1:0] a);
      return IdxW'(32'(a) % DEPTH);
   endfunction

`ifdef MEMRESP_OOR_ERR_EN
   logic oor_q, oor_d;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < DEPTH;
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
`ifdef MEMRESP_OOR_ERR_EN
      oor_d   = oor_q;
`endif
      case (state_q)
         StIdle: begin
            if (read_i || write_i) begin
               addr_d  = addr_i;
               wdata_d = wdata_i;
               we_d    = write_i;
               cnt_d   = 4'(WAIT_STATES);
`ifdef MEMRESP_OOR_ERR_EN
               oor_d   = !in_range(addr_i);
`endif
               state_d = (WAIT_STATES == 0) ? StResp : StWait;
            end
         end
         StWait: begin
            if (!read_i && !write_i) begin
               cnt_d   = 4'd0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Read data is fetched on the edge entering RESP so a same-cycle load cannot race it.
      if (state_d == StResp && !we_d) begin
         rdata_d = mem_q[wrap_idx(addr_d)];
`ifdef MEMRESP_OOR_ERR_EN
         if (oor_d) rdata_d = 8'hFF;
`endif
      end
   end

   always_comb begin
      commit = (state_q == StResp) && we_q && !reset_i;
`ifdef MEMRESP_OOR_ERR_EN
      if (oor_q) commit = 1'b0;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 8'h00;
         we_q    <= 1'b0;
         rdata_q <= 8'h00;
`ifdef MEMRESP_OOR_ERR_EN
         oor_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
`ifdef MEMRESP_OOR_ERR_EN
         oor_q   <= oor_d;
`endif
      end
   end

   // Loader is independent of reset; the request write is last so it wins a same-address clash.
   always_ff @(posedge clk_i) begin
`ifdef MEMRESP_OOR_ERR_EN
      if (ld_en_i && in_range(ld_addr_i)) mem_q[wrap_idx(ld_addr_i)] <= ld_data_i;
`else
      if (ld_en_i) mem_q[wrap_idx(ld_addr_i)] <= ld_data_i;
`endif
      if (commit) mem_q[wrap_idx(addr_q)] <= wdata_q;
   end

   assign rdata_o = rdata_q;
   assign ready_o = (state_q == StResp);
   assign busy_o  = (state_q != StIdle);
`ifdef MEMRESP_OOR_ERR_EN
   assign err_o   = (state_q == StResp) && oor_q;
`endif

endmodule

// File: tb/tb_mem_responder_8085.sv
// Scoreboard bench: dut1 has one wait state and 256 bytes, dut0 has zero wait states and 128 bytes.
module tb_mem_responder_8085;

   localparam int unsigned Ws0 = 0;
   localparam int unsigned Ws1 = 1;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] rd, wr, lden, rdy, bsy;
   logic [7:0] ad [2];
   logic [7:0] wd [2];
   logic [7:0] la [2];
   logic [7:0] ld [2];
   logic [7:0] rdat [2];
`ifdef MEMRESP_OOR_ERR_EN
   logic [1:0] err;
`endif

   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   exp_t q0 [$];
   exp_t q1 [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder_8085 #(.ADDR_W(8), .DEPTH(128), .WAIT_STATES(Ws0)) u_dut0 (
      .clk_i(clk), .reset_i(reset), .read_i(rd[0]), .write_i(wr[0]), .addr_i(ad[0]),
      .wdata_i(wd[0]), .rdata_o(rdat[0]), .ready_o(rdy[0]), .busy_o(bsy[0]),
      .ld_en_i(lden[0]), .ld_addr_i(la[0]), .ld_data_i(ld[0])
`ifdef MEMRESP_OOR_ERR_EN
      , .err_o(err[0])
`endif
   );

   mem_responder_8085 #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(Ws1)) u_dut1 (
      .clk_i(clk), .reset_i(reset), .read_i(rd[1]), .write_i(wr[1]), .addr_i(ad[1]),
      .wdata_i(wd[1]), .rdata_o(rdat[1]), .ready_o(rdy[1]), .busy_o(bsy[1]),
      .ld_en_i(lden[1]), .ld_addr_i(la[1]), .ld_data_i(ld[1])
`ifdef MEMRESP_OOR_ERR_EN
      , .err_o(err[1])
`endif
   );

   function automatic int ws(input int k);
      return (k == 0) ? int'(Ws0) : int'(Ws1);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ready strobe must match the head of that DUT's expectation queue.
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      for (int k = 0; k < 2; k++) begin
         if (rdy[k] === 1'b1) begin
            have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
            n_checks++;
            if (!have) begin
               n_err++;
               $display("FAIL ready_unexpected dut%0d: ready=1 at cycle %0d, required none",
                        k, cyc);
            end else begin
               if (k == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               if (cyc != e.cyc) begin
                  n_err++;
                  $display("FAIL ready_cycle dut%0d: got cycle %0d, required %0d", k, cyc, e.cyc);
               end
               n_checks++;
               if (rdat[k] !== e.data) begin
                  n_err++;
                  $display("FAIL rdata dut%0d: got %h, required %h", k, rdat[k], e.data);
               end
            end
         end
      end
   end

   task automatic load(input int k, input logic [7:0] a, input logic [7:0] d);
      la[k] = a; ld[k] = d; lden[k] = 1'b1;
      @(posedge clk); #1;
      lden[k] = 1'b0;
   endtask

   // Request held until the RESP cycle; addr/wdata scrambled after acceptance.
   task automatic req(input int k, input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] e, input logic l = 1'b0,
                      input logic [7:0] lad = 8'h00, input logic [7:0] ldd = 8'h00);
      exp_t x;
      x.data = e;
      x.cyc  = cyc + 1 + ws(k);
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
      rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
      for (int i = 0; i <= ws(k) + 1; i++) begin
         @(negedge clk);
         chk("busy", 8'(bsy[k]), 8'(i != 0));
         @(posedge clk); #1;
         if (i == 0) begin
            ad[k] = ~a; wd[k] = ~d;
         end
         if (i == ws(k)) begin
            rd[k] = 1'b0; wr[k] = 1'b0;
            if (l) begin
               la[k] = lad; ld[k] = ldd; lden[k] = 1'b1;
            end
         end
         if (i == ws(k) + 1) lden[k] = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      rd = '0; wr = '0; lden = '0;
      for (int k = 0; k < 2; k++) begin
         ad[k] = 8'h00; wd[k] = 8'h00; la[k] = 8'h00; ld[k] = 8'h00;
      end
      // Loader must work while reset is held.
      la[1] = 8'h10; ld[1] = 8'h3C; lden[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      lden[1] = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset_ready", 8'(rdy[k]), 8'h00);
         chk("reset_busy", 8'(bsy[k]), 8'h00);
         chk("reset_rdata", rdat[k], 8'h00);
      end
      @(posedge clk); #1;

      load(1, 8'h30, 8'h55);
      load(1, 8'h40, 8'h66);
      load(1, 8'h70, 8'h01);
      load(0, 8'h00, 8'h11);
      load(0, 8'h01, 8'h22);
      load(0, 8'h10, 8'h5A);

      // dut1, one wait state
      req(1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h3C);
      req(1, 1'b0, 1'b1, 8'h20, 8'hA5, 8'h3C);
      req(1, 1'b1, 1'b0, 8'h20, 8'h00, 8'hA5);

      // Abort: write dropped during WAIT, no ready and no commit.
      rd[1] = 1'b0; wr[1] = 1'b1; ad[1] = 8'h30; wd[1] = 8'h77;
      @(posedge clk); #1;
      wr[1] = 1'b0;
      @(negedge clk);
      chk("abort_busy_wait", 8'(bsy[1]), 8'h01);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_busy_idle", 8'(bsy[1]), 8'h00);
      @(posedge clk); #1;
      req(1, 1'b1, 1'b0, 8'h30, 8'h00, 8'h55);

      // Read and write together performs the write.
      req(1, 1'b1, 1'b1, 8'h50, 8'hC3, 8'h55);
      req(1, 1'b1, 1'b0, 8'h50, 8'h00, 8'hC3);

      // Request write beats a same-cycle loader write; RESP read sees pre-load data.
      req(1, 1'b0, 1'b1, 8'h60, 8'h12, 8'hC3, 1'b1, 8'h60, 8'h34);
      req(1, 1'b1, 1'b0, 8'h60, 8'h00, 8'h12);
      req(1, 1'b1, 1'b0, 8'h70, 8'h00, 8'h01, 1'b1, 8'h70, 8'h02);
      req(1, 1'b1, 1'b0, 8'h70, 8'h00, 8'h02);

      // dut0: zero wait states back-to-back, then modulo-128 wrap.
      req(0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h11);
      req(0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h22);
      req(0, 1'b1, 1'b0, 8'h90, 8'h00, 8'h5A);
      load(0, 8'h81, 8'h7E);
      req(0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h7E);
      req(0, 1'b0, 1'b1, 8'hA0, 8'h3D, 8'h7E);
      req(0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3D);

      // Reset during WAIT of a write discards it.
      rd[1] = 1'b0; wr[1] = 1'b1; ad[1] = 8'h40; wd[1] = 8'hEE;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; wr[1] = 1'b0;
      @(negedge clk);
      chk("midreset_ready", 8'(rdy[1]), 8'h00);
      chk("midreset_busy", 8'(bsy[1]), 8'h00);
      chk("midreset_rdata", rdat[1], 8'h00);
      @(posedge clk); #1;
      req(1, 1'b1, 1'b0, 8'h40, 8'h00, 8'h66);

      repeat (4) @(posedge clk);
      #1;
      chk("pending_dut0", 8'(q0.size()), 8'h00);
      chk("pending_dut1", 8'(q1.size()), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
